// File: rtl/fadd_issue_pkg.sv
// Shared FPU definitions for the FADD/FSUB issue wrapper: operand width,
// sign bit position, op encoding and the sign-adjust used to turn FSUB into FADD.
package fadd_issue_pkg;
  localparam int FP_W      = 32;
  localparam int FP_SIGN   = 31;
  localparam int TAG_W_DEF = 6;

  typedef enum logic {
    FOP_ADD = 1'b0,
    FOP_SUB = 1'b1
  } fop_e;

  // x1 - x2 is computed as x1 + (-x2); only the sign bit of x2 is touched.
  function automatic logic [FP_W-1:0] fp_apply_op(input logic [FP_W-1:0] x, input logic negate);
    fp_apply_op = {x[FP_SIGN] ^ negate, x[FP_SIGN-1:0]};
  endfunction
endpackage

// File: rtl/fadd_issue_if.sv
// Request/response handshake bundle between FP dispatch, the FADD issue unit
// and the result consumer. slave = issue unit side, master = dispatch/consumer side.
interface fadd_issue_if
  import fadd_issue_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic [FP_W-1:0]  in_x1;
  logic [FP_W-1:0]  in_x2;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [FP_W-1:0]  out_y;

  modport master (
    output in_valid, in_sub, in_tag, in_x1, in_x2, out_ready,
    input  in_ready, out_valid, out_tag, out_y
  );

  modport slave (
    input  in_valid, in_sub, in_tag, in_x1, in_x2, out_ready,
    output in_ready, out_valid, out_tag, out_y
  );
endinterface

// File: rtl/fpu_pipe_reg.sv
// One-entry valid/ready register slice with synchronous flush. Accepts whenever
// empty or draining, so a full slice with a ready consumer passes one item per cycle.
module fpu_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Flush drops the entry but leaves the data register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/fadd_issue.sv
// Two-stage issue/retire wrapper around the external combinational fadd:
// stage A drives the adder operands, stage B captures the sum with its tag.
module fadd_issue
  import fadd_issue_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  fadd_issue_if.slave     io,
  output logic [FP_W-1:0] add_x1,
  output logic [FP_W-1:0] add_x2,
  input  logic [FP_W-1:0] add_y,
  output logic            busy
);
  logic             a_valid_q, a_valid_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;
  logic [FP_W-1:0]  x1_q, x1_d;
  logic [FP_W-1:0]  x2_q, x2_d;

  logic             adv_a;
  logic             adv_b;
  logic             accept;
  logic             b_valid;
  logic [TAG_W+FP_W-1:0] b_in;
  logic [TAG_W+FP_W-1:0] b_out;

  assign adv_a       = a_valid_q & adv_b;
  assign io.in_ready = !a_valid_q | adv_b;
  assign accept      = io.in_valid & io.in_ready;

  // Stage A: a new request may load in the same cycle A hands off to B.
  always_comb begin
    a_valid_d = a_valid_q;
    a_tag_d   = a_tag_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (accept) begin
      a_valid_d = 1'b1;
      a_tag_d   = io.in_tag;
      x1_d      = io.in_x1;
      x2_d      = fp_apply_op(io.in_x2, io.in_sub == FOP_SUB);
    end else if (adv_a) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_valid_q <= 1'b0;
      a_tag_q   <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_tag_q   <= a_tag_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
    end
  end

  assign add_x1 = x1_q;
  assign add_x2 = x2_q;

  // Stage B: the adder output is only sampled here, so A must hold while B stalls.
  assign b_in = {a_tag_q, add_y};

  fpu_pipe_reg #(
    .W(TAG_W + FP_W)
  ) u_stage_b (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (a_valid_q),
    .in_ready  (adv_b),
    .in_data   (b_in),
    .out_valid (b_valid),
    .out_ready (io.out_ready),
    .out_data  (b_out)
  );

  assign io.out_valid = b_valid;
  assign io.out_tag   = b_out[TAG_W+FP_W-1:FP_W];
  assign io.out_y     = b_out[FP_W-1:0];
  assign busy         = a_valid_q | b_valid;
endmodule

// File: tb/tb_fadd_issue.sv
// Self-checking bench for fadd_issue: real-arithmetic adder stand-in, a
// transaction-level scoreboard, and one task per scenario.
module tb_fadd_issue;
  localparam int TW = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [31:0] add_x1, add_x2, add_y;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fadd_issue_if #(.TAG_W(TW)) io ();

  fadd_issue #(.TAG_W(TW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .flush  (flush),
    .io     (io),
    .add_x1 (add_x1),
    .add_x2 (add_x2),
    .add_y  (add_y),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Single <-> double conversion for zero and normal numbers only.
  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return b[31] ? -0.0 : 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] x1, input logic [31:0] x2, input logic sub);
    return sub ? r2sp(sp2r(x1) - sp2r(x2)) : r2sp(sp2r(x1) + sp2r(x2));
  endfunction

  // Small signed integers keep every sum exactly representable.
  function automatic logic [31:0] rnd_fp();
    real r;
    r = real'($urandom_range(1, 1000));
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2sp(r);
  endfunction

  // Stand-in for the external fadd block.
  always_comb add_y = r2sp(sp2r(add_x1) + sp2r(add_x2));

  // Scoreboard: accepted requests become expectations; retirements pair with them.
  logic [TW+31:0] exp_q[$];
  logic [TW+31:0] act_q[$];
  logic [TW+31:0] expd_q[$];
  int             cyc_q[$];
  int             orphan = 0;
  int             cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rstn || flush) begin
      exp_q.delete();
    end else begin
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) orphan = orphan + 1;
        else begin
          expd_q.push_back(exp_q.pop_front());
          act_q.push_back({io.out_tag, io.out_y});
          cyc_q.push_back(cyc);
        end
      end
      if (io.in_valid && io.in_ready)
        exp_q.push_back({io.in_tag, ref_result(io.in_x1, io.in_x2, io.in_sub)});
    end
  end

  task automatic clr_mon();
    exp_q.delete();
    act_q.delete();
    expd_q.delete();
    cyc_q.delete();
    orphan = 0;
  endtask

  task automatic idle_inputs();
    io.in_valid  = 1'b0;
    io.in_sub    = 1'b0;
    io.in_tag    = '0;
    io.in_x1     = '0;
    io.in_x2     = '0;
    io.out_ready = 1'b1;
    flush        = 1'b0;
  endtask

  task automatic drive_req(input logic [TW-1:0] tag, input logic [31:0] x1, input logic [31:0] x2, input logic sub);
    io.in_valid = 1'b1;
    io.in_tag   = tag;
    io.in_x1    = x1;
    io.in_x2    = x2;
    io.in_sub   = sub;
  endtask

  task automatic wait_retired(input int n, input int budget);
    for (int i = 0; i < budget && act_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", io.in_ready); end
    n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", io.out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_tests++; if (io.out_y !== 32'h0) begin n_fail++; $display("FAIL reset_out_y got=%h want=0", io.out_y); end
    n_tests++; if (io.out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", io.out_tag); end
    n_tests++; if ({add_x1, add_x2} !== 64'h0) begin n_fail++; $display("FAIL reset_add_x got=%h/%h want=0/0", add_x1, add_x2); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_fadd();
    clr_mon();
    drive_req(6'd5, 32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk);
    io.in_valid = 1'b0;
    #1;
    n_tests++; if (add_x1 !== 32'h3F800000 || add_x2 !== 32'h40000000) begin n_fail++; $display("FAIL fadd_operands got=%h/%h want=3f800000/40000000", add_x1, add_x2); end
    n_tests++; if (io.out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fadd_stage_a got vld=%b busy=%b want 0/1", io.out_valid, busy); end
    @(negedge clk); #1;
    n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL fadd_latency out_valid got=%b want=1", io.out_valid); end
    n_tests++; if (io.out_y !== 32'h40400000 || io.out_tag !== 6'd5) begin n_fail++; $display("FAIL fadd_result got=%h tag=%0d want=40400000 tag=5", io.out_y, io.out_tag); end
    @(negedge clk); #1;
    n_tests++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fadd_drain got vld=%b busy=%b want 0/0", io.out_valid, busy); end
  endtask

  task automatic test_fsub();
    clr_mon();
    drive_req(6'd9, 32'h40400000, 32'h3F800000, 1'b1);
    @(negedge clk);
    drive_req(6'd10, 32'h3F800000, 32'h3F800000, 1'b1);
    #1;
    n_tests++; if (add_x2 !== 32'hBF800000 || add_x1 !== 32'h40400000) begin n_fail++; $display("FAIL fsub_sign_flip got=%h/%h want=40400000/bf800000", add_x1, add_x2); end
    @(negedge clk);
    io.in_valid = 1'b0;
    #1;
    n_tests++; if (io.out_valid !== 1'b1 || io.out_y !== 32'h40000000 || io.out_tag !== 6'd9) begin n_fail++; $display("FAIL fsub_result got vld=%b y=%h tag=%0d want 1/40000000/9", io.out_valid, io.out_y, io.out_tag); end
    @(negedge clk); #1;
    n_tests++; if (io.out_valid !== 1'b1 || io.out_y !== 32'h00000000 || io.out_tag !== 6'd10) begin n_fail++; $display("FAIL fsub_zero got vld=%b y=%h tag=%0d want 1/00000000/10", io.out_valid, io.out_y, io.out_tag); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clr_mon();
    io.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_req(TW'(i), rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
      #1;
      n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready req=%0d got=%b want=1", i, io.in_ready); end
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    wait_retired(8, 20);
    n_tests++; if (act_q.size() != 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", act_q.size()); end
    for (int i = 0; i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== expd_q[i] || act_q[i][TW+31:32] !== TW'(i) || cyc_q[i] != cyc_q[0] + i) begin
        n_fail++;
        $display("FAIL b2b_result idx=%0d got=%h cyc=%0d want=%h tag=%0d cyc=%0d", i, act_q[i], cyc_q[i], expd_q[i], i, cyc_q[0] + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rx1[3], rx2[3];
    logic        exp_rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] held_y;
    int          idx = 0;
    clr_mon();
    for (int i = 0; i < 3; i++) begin rx1[i] = rnd_fp(); rx2[i] = rnd_fp(); end
    for (int k = 0; k < 5; k++) begin
      io.out_ready = (k == 4);
      if (idx < 3) drive_req(TW'(20 + idx), rx1[idx], rx2[idx], 1'b0);
      else io.in_valid = 1'b0;
      #1;
      n_tests++; if (io.in_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", k, io.in_ready, exp_rdy[k]); end
      if (k == 2) held_y = io.out_y;
      if (k >= 2) begin
        n_tests++;
        if (io.out_valid !== 1'b1 || io.out_tag !== TW'(20) || io.out_y !== held_y || held_y !== ref_result(rx1[0], rx2[0], 1'b0)) begin
          n_fail++;
          $display("FAIL bp_hold cycle=%0d got vld=%b tag=%0d y=%h want 1/20/%h", k, io.out_valid, io.out_tag, io.out_y, ref_result(rx1[0], rx2[0], 1'b0));
        end
      end
      if (io.in_ready && idx < 3) idx++;
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    n_tests++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepted got=%0d want=3", idx); end
    wait_retired(3, 10);
    n_tests++; if (act_q.size() != 3) begin n_fail++; $display("FAIL bp_count got=%0d want=3", act_q.size()); end
    for (int i = 0; i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== {TW'(20 + i), ref_result(rx1[i], rx2[i], 1'b0)}) begin
        n_fail++;
        $display("FAIL bp_order idx=%0d got=%h want=%h", i, act_q[i], {TW'(20 + i), ref_result(rx1[i], rx2[i], 1'b0)});
      end
    end
  endtask

  task automatic test_flush();
    clr_mon();
    io.out_ready = 1'b0;
    drive_req(6'd30, rnd_fp(), rnd_fp(), 1'b0);
    @(negedge clk);
    drive_req(6'd31, rnd_fp(), rnd_fp(), 1'b1);
    @(negedge clk);
    drive_req(6'd32, rnd_fp(), rnd_fp(), 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    io.in_valid = 1'b0;
    #1;
    n_tests++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_state got vld=%b busy=%b want 0/0", io.out_valid, busy); end
    n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b want=1", io.in_ready); end
    io.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++; if (act_q.size() != 0 || orphan != 0) begin n_fail++; $display("FAIL flush_leak got retired=%0d orphan=%0d want 0/0", act_q.size(), orphan); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fx1, fx2;
    clr_mon();
    io.out_ready = 1'b1;
    drive_req(6'd40, rnd_fp(), rnd_fp(), 1'b0);
    @(negedge clk);
    drive_req(6'd41, rnd_fp(), rnd_fp(), 1'b1);
    @(negedge clk);
    io.in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_tests++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got vld=%b rdy=%b busy=%b want 0/1/0", io.out_valid, io.in_ready, busy); end
    n_tests++; if (io.out_y !== 32'h0 || add_x1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data got y=%h x1=%h want 0/0", io.out_y, add_x1); end
    clr_mon();
    fx1 = rnd_fp(); fx2 = rnd_fp();
    drive_req(6'd42, fx1, fx2, 1'b1);
    @(negedge clk);
    io.in_valid = 1'b0;
    wait_retired(1, 10);
    n_tests++; if (act_q.size() != 1 || orphan != 0) begin n_fail++; $display("FAIL rst_mid_count got=%0d orphan=%0d want 1/0", act_q.size(), orphan); end
    else begin
      n_tests++; if (act_q[0] !== {6'd42, ref_result(fx1, fx2, 1'b1)}) begin n_fail++; $display("FAIL rst_mid_fresh got=%h want=%h", act_q[0], {6'd42, ref_result(fx1, fx2, 1'b1)}); end
    end
  endtask

  task automatic test_random();
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y = '0;
    logic [TW-1:0] prev_tag = '0;
    logic        pending = 1'b0;
    int          tag = 0;
    clr_mon();
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          drive_req(TW'(tag), rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
          tag = tag + 1;
          pending = 1'b1;
        end else io.in_valid = 1'b0;
      end
      io.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_tests++;
        if (io.out_valid !== 1'b1 || io.out_y !== prev_y || io.out_tag !== prev_tag) begin
          n_fail++;
          $display("FAIL rand_stall_hold cycle=%0d got vld=%b y=%h tag=%0d want 1/%h/%0d", c, io.out_valid, io.out_y, io.out_tag, prev_y, prev_tag);
        end
      end
      prev_stall = io.out_valid && !io.out_ready;
      prev_y     = io.out_y;
      prev_tag   = io.out_tag;
      if (io.in_valid && io.in_ready) pending = 1'b0;
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 10 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    n_tests++; if (exp_q.size() != 0 || orphan != 0) begin n_fail++; $display("FAIL rand_drain got pending=%0d orphan=%0d want 0/0", exp_q.size(), orphan); end
    n_tests++; if (act_q.size() < 50) begin n_fail++; $display("FAIL rand_volume got=%0d want>=50", act_q.size()); end
    for (int i = 0; i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== expd_q[i]) begin
        n_fail++;
        $display("FAIL rand_result idx=%0d got=%h want=%h", i, act_q[i], expd_q[i]);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fadd();
    test_fsub();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
